// File: rtl/bitmap_scanout.sv
// Reads the circle-plot bitmap through the coprocessor slave port and writes it as packed 32-bit words to a frame buffer.
// Define SCANOUT_ZERO_SKIP_EN to suppress frame buffer writes of all-zero words.
//
// state  | meaning
// IDLE   | waiting for start
// POLL   | reading the coprocessor status register until it reports idle
// STREAM | issuing byte reads, packing bytes, writing words
// DONE   | one-cycle completion pulse
module bitmap_scanout #(
    parameter int DATAW      = 18,
    parameter int ROWS       = 512,
    parameter int ROW_BYTES  = 64,
    parameter int FIFO_DEPTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [31:0]      fb_base,
    output logic             busy,
    output logic             done,
    output logic             cread,
    output logic [DATAW:0]   caddress,
    input  logic [31:0]      creaddata,
    input  logic             creaddatavalid,
    output logic             fwrite,
    output logic [31:0]      faddress,
    output logic [31:0]      fwritedata,
    input  logic             fwaitrequest
);
    localparam int TOTAL_BYTES = ROWS * ROW_BYTES;
    localparam int TOTAL_WORDS = TOTAL_BYTES / 4;
    localparam int BIW         = $clog2(TOTAL_BYTES) + 1;
    localparam int WIW         = $clog2(TOTAL_WORDS);
    localparam int PW          = $clog2(FIFO_DEPTH);
    localparam int CW          = PW + 1;

    typedef enum logic [1:0] {S_IDLE, S_POLL, S_STREAM, S_DONE} state_t;
    state_t r_state, w_next;

    logic [31:0]    r_base;
    logic [BIW-1:0] r_byte_idx;
    logic [WIW-1:0] r_word_idx;
    logic [CW-1:0]  r_out;
    logic [CW-1:0]  r_cnt;
    logic [PW-1:0]  r_wptr;
    logic [PW-1:0]  r_rptr;
    logic [7:0]     r_fifo [FIFO_DEPTH];
    logic [31:0]    r_shift;
    logic [1:0]     r_nbytes;
    logic           r_fwrite;
    logic [31:0]    r_faddr;
    logic [31:0]    r_fdata;

    logic        w_issue;
    logic        w_push;
    logic        w_pop;
    logic        w_accept;
    logic        w_word_done;
    logic        w_skip;
    logic        w_emit;
    logic        w_last;
    logic [31:0] w_word;
    logic        w_unused;

    assign w_issue     = (r_state == S_STREAM)
                         && ((int'(r_out) + int'(r_cnt)) < FIFO_DEPTH)
                         && (r_byte_idx < BIW'(TOTAL_BYTES));
    // Only responses to stream reads carry bitmap bytes; anything else is a stray.
    assign w_push      = creaddatavalid && (r_out != '0) && (r_state == S_STREAM);
    assign w_pop       = (r_state == S_STREAM) && !r_fwrite && (r_cnt != '0);
    assign w_word      = {r_fifo[r_rptr], r_shift[31:8]};
    assign w_word_done = w_pop && (r_nbytes == 2'd3);
    assign w_accept    = r_fwrite && !fwaitrequest;
    assign w_last      = (r_word_idx == WIW'(TOTAL_WORDS - 1));
`ifdef SCANOUT_ZERO_SKIP_EN
    assign w_skip      = w_word_done && (w_word == 32'h0);
`else
    assign w_skip      = 1'b0;
`endif
    assign w_emit      = w_word_done && !w_skip;
    assign w_unused    = ^creaddata[31:8];

    assign fwrite     = r_fwrite;
    assign faddress   = r_faddr;
    assign fwritedata = r_fdata;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next   = r_state;
        busy     = 1'b0;
        done     = 1'b0;
        cread    = 1'b0;
        caddress = '0;
        case (r_state)
            S_IDLE: begin
                if (start) w_next = S_POLL;
            end
            S_POLL: begin
                busy     = 1'b1;
                cread    = 1'b1;
                caddress = {1'b1, {DATAW{1'b0}}};
                if (creaddatavalid && !creaddata[0]) w_next = S_STREAM;
            end
            S_STREAM: begin
                busy  = 1'b1;
                cread = w_issue;
                if (w_issue) caddress = {1'b0, DATAW'(r_byte_idx)};
                if ((w_accept || w_skip) && w_last) w_next = S_DONE;
            end
            S_DONE: begin
                done   = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_push) r_fifo[r_wptr] <= creaddata[7:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_base     <= '0;
            r_byte_idx <= '0;
            r_word_idx <= '0;
            r_out      <= '0;
            r_cnt      <= '0;
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_shift    <= '0;
            r_nbytes   <= '0;
            r_fwrite   <= 1'b0;
            r_faddr    <= '0;
            r_fdata    <= '0;
        end else begin
            if ((r_state == S_IDLE) && start) begin
                r_base     <= fb_base;
                r_byte_idx <= '0;
                r_word_idx <= '0;
                r_nbytes   <= '0;
            end
            if (w_issue) r_byte_idx <= r_byte_idx + 1'b1;
            if (w_issue && !w_push) begin
                r_out <= r_out + 1'b1;
            end else if (!w_issue && w_push) begin
                r_out <= r_out - 1'b1;
            end
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_push && !w_pop) begin
                r_cnt <= r_cnt + 1'b1;
            end else if (!w_push && w_pop) begin
                r_cnt <= r_cnt - 1'b1;
            end
            if (w_pop) begin
                r_rptr   <= r_rptr + 1'b1;
                r_shift  <= w_word;
                r_nbytes <= r_nbytes + 1'b1;
            end
            // Address and data stay put after acceptance; only the strobe drops.
            if (w_emit) begin
                r_fwrite <= 1'b1;
                r_faddr  <= r_base + 32'({r_word_idx, 2'b00});
                r_fdata  <= w_word;
            end else if (w_accept) begin
                r_fwrite <= 1'b0;
            end
            if (w_accept || w_skip) r_word_idx <= r_word_idx + 1'b1;
        end
    end
endmodule

// File: tb/tb_bitmap_scanout.sv
// Self-checking bench for bitmap_scanout: coprocessor slave model with in-order variable latency,
// frame buffer stall injection, and a write scoreboard filled from the bitmap model at scan start.
module tb_bitmap_scanout;
    localparam int DATAW      = 18;
    localparam int ROWS       = 16;
    localparam int ROW_BYTES  = 64;
    localparam int FIFO_DEPTH = 8;
    localparam int TB         = ROWS * ROW_BYTES;
    localparam int TW         = TB / 4;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             start = 1'b0;
    logic [31:0]      fb_base = 32'h0;
    logic             busy;
    logic             done;
    logic             cread;
    logic [DATAW:0]   caddress;
    logic [31:0]      creaddata = 32'h0;
    logic             creaddatavalid = 1'b0;
    logic             fwrite;
    logic [31:0]      faddress;
    logic [31:0]      fwritedata;
    logic             fwaitrequest = 1'b0;

    bitmap_scanout #(
        .DATAW(DATAW), .ROWS(ROWS), .ROW_BYTES(ROW_BYTES), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .fb_base(fb_base),
        .busy(busy), .done(done), .cread(cread), .caddress(caddress),
        .creaddata(creaddata), .creaddatavalid(creaddatavalid),
        .fwrite(fwrite), .faddress(faddress), .fwritedata(fwritedata),
        .fwaitrequest(fwaitrequest)
    );

    always #5 clk = ~clk;

    typedef struct { int due; logic [7:0] data; bit live; } rsp_t;
    typedef struct { logic [31:0] addr; logic [31:0] data; } wr_t;

    rsp_t        pend_q[$];
    wr_t         exp_q[$];
    logic [7:0]  mem [TB];

    int tests_run = 0, fails = 0;
    int cyc = 0, poll_cnt = 0, poll_ones = 0, rd_idx = 0, b_out = 0, max_out = 0;
    int lat_min = 1, lat_max = 1, stall_word = -1, stall_len = 0, stall_left = 0, stall_reads = 0;
    int wr_cnt = 0, done_cnt = 0, exp_n = 0;
    bit rand_stall = 0, wr_seen = 0, prev_stall = 0;
    logic [31:0] first_a, first_d, last_a, last_d, prev_a, prev_d;

    // Slave model, stall injection and write/done monitor, all evaluated on the falling edge.
    always @(negedge clk) begin
        rsp_t r;
        wr_t  e;
        cyc++;
        creaddatavalid = 1'b0;
        creaddata      = 32'h0;
        fwaitrequest   = 1'b0;
        if (cread && caddress[DATAW]) begin
            tests_run++;
            if (caddress !== {1'b1, {DATAW{1'b0}}}) begin
                fails++; $display("FAIL poll_addr got=%h want=%h", caddress, {1'b1, {DATAW{1'b0}}});
            end
            creaddatavalid = 1'b1;
            creaddata      = {24'hA5A5A5, 7'h55, (poll_cnt < poll_ones)};
            poll_cnt++;
        end else begin
            if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
                r = pend_q.pop_front();
                creaddatavalid = 1'b1;
                creaddata      = {24'hC3E1A5, r.data};
                if (r.live) b_out--;
            end
            if (cread) begin
                tests_run++;
                if (caddress !== (DATAW+1)'(rd_idx)) begin
                    fails++; $display("FAIL read_addr got=%h want=%h", caddress, (DATAW+1)'(rd_idx));
                end
                r.due  = cyc + $urandom_range(lat_max, lat_min);
                r.data = mem[int'(caddress[DATAW-1:0]) % TB];
                r.live = 1'b1;
                pend_q.push_back(r);
                rd_idx++;
                b_out++;
                if (b_out > max_out) max_out = b_out;
            end
        end
        if (fwrite) begin
            if (wr_cnt == stall_word && stall_left > 0) begin
                fwaitrequest = 1'b1;
                if (stall_left <= 10 && cread) stall_reads++;
                stall_left--;
            end else if (rand_stall && $urandom_range(0, 3) == 0) begin
                fwaitrequest = 1'b1;
            end
        end
        if (prev_stall && !reset) begin
            tests_run++;
            if (fwrite !== 1'b1 || faddress !== prev_a || fwritedata !== prev_d) begin
                fails++;
                $display("FAIL write_hold got=%b/%h/%h want=1/%h/%h", fwrite, faddress, fwritedata, prev_a, prev_d);
            end
        end
        prev_stall = fwrite && fwaitrequest && !reset;
        prev_a     = faddress;
        prev_d     = fwritedata;
        if (fwrite && !fwaitrequest) begin
            wr_cnt++;
            if (!wr_seen) begin first_a = faddress; first_d = fwritedata; wr_seen = 1'b1; end
            last_a = faddress;
            last_d = fwritedata;
            tests_run++;
            if (exp_q.size() == 0) begin
                fails++; $display("FAIL unexpected_write got=%h/%h want=none", faddress, fwritedata);
            end else begin
                e = exp_q.pop_front();
                if (faddress !== e.addr || fwritedata !== e.data) begin
                    fails++;
                    $display("FAIL write_data got=%h/%h want=%h/%h", faddress, fwritedata, e.addr, e.data);
                end
            end
        end
        if (done) begin
            done_cnt++;
            tests_run++;
            if (busy !== 1'b0) begin fails++; $display("FAIL busy_at_done got=%b want=0", busy); end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic fill_random();
        for (int i = 0; i < TB; i += 4) begin
            bit z = ($urandom_range(0, 3) == 0);
            for (int k = 0; k < 4; k++) mem[i+k] = z ? 8'h00 : 8'($urandom);
        end
    endtask

    task automatic fill_zero();
        for (int i = 0; i < TB; i++) mem[i] = 8'h00;
    endtask

    task automatic scan_start(input logic [31:0] base, input int ones);
        poll_cnt = 0; poll_ones = ones; wr_cnt = 0; done_cnt = 0; rd_idx = 0;
        b_out = 0; max_out = 0; wr_seen = 0; stall_left = stall_len; stall_reads = 0;
        exp_q.delete();
        for (int w = 0; w < TW; w++) begin
            wr_t e;
            e.addr = base + 32'(4 * w);
            e.data = {mem[4*w+3], mem[4*w+2], mem[4*w+1], mem[4*w]};
`ifdef SCANOUT_ZERO_SKIP_EN
            if (e.data != 32'h0) exp_q.push_back(e);
`else
            exp_q.push_back(e);
`endif
        end
        exp_n = exp_q.size();
        fb_base = base;
        start   = 1'b1;
        tick();
        start   = 1'b0;
        fb_base = 32'hDEAD_BEEF;
        tick();
        tests_run++;
        if (busy !== 1'b1) begin fails++; $display("FAIL busy_after_start got=%b want=1", busy); end
    endtask

    task automatic scan_finish(input int ones);
        int i;
        i = 0;
        while (done_cnt == 0 && i < 20000) begin tick(); i++; end
        tests_run++;
        if (done_cnt == 0) begin fails++; $display("FAIL scan_timeout got=no_done want=done"); end
        repeat (3) tick();
        tests_run++;
        if (done_cnt !== 1) begin fails++; $display("FAIL done_pulses got=%0d want=1", done_cnt); end
        tests_run++;
        if (wr_cnt !== exp_n) begin fails++; $display("FAIL write_count got=%0d want=%0d", wr_cnt, exp_n); end
        tests_run++;
        if (exp_q.size() !== 0) begin fails++; $display("FAIL missing_writes got=%0d want=0", exp_q.size()); end
        tests_run++;
        if (poll_cnt !== ones + 1) begin fails++; $display("FAIL poll_count got=%0d want=%0d", poll_cnt, ones + 1); end
        tests_run++;
        if (busy !== 1'b0) begin fails++; $display("FAIL busy_after_done got=%b want=0", busy); end
    endtask

    task automatic check_reset_outputs(input string tag);
        tests_run++;
        if (busy !== 1'b0) begin fails++; $display("FAIL %s_busy got=%b want=0", tag, busy); end
        tests_run++;
        if (done !== 1'b0) begin fails++; $display("FAIL %s_done got=%b want=0", tag, done); end
        tests_run++;
        if (cread !== 1'b0) begin fails++; $display("FAIL %s_cread got=%b want=0", tag, cread); end
        tests_run++;
        if (caddress !== '0) begin fails++; $display("FAIL %s_caddress got=%h want=0", tag, caddress); end
        tests_run++;
        if (fwrite !== 1'b0) begin fails++; $display("FAIL %s_fwrite got=%b want=0", tag, fwrite); end
        tests_run++;
        if (faddress !== 32'h0) begin fails++; $display("FAIL %s_faddress got=%h want=0", tag, faddress); end
        tests_run++;
        if (fwritedata !== 32'h0) begin fails++; $display("FAIL %s_fwritedata got=%h want=0", tag, fwritedata); end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) tick();
        check_reset_outputs("reset");
        reset = 1'b0;
        repeat (2) tick();
        tests_run++;
        if (busy !== 1'b0 || cread !== 1'b0) begin
            fails++; $display("FAIL idle_after_reset got=%b/%b want=0/0", busy, cread);
        end
    endtask

    task automatic test_zero_scan();
        fill_zero();
        lat_min = 1; lat_max = 1; stall_len = 0; rand_stall = 0;
        scan_start(32'h0000_1000, 5);
        scan_finish(5);
`ifndef SCANOUT_ZERO_SKIP_EN
        tests_run++;
        if (last_a !== 32'h1000 + 32'(4 * (TW - 1)) || last_d !== 32'h0) begin
            fails++; $display("FAIL zero_last_write got=%h/%h want=%h/0", last_a, last_d, 32'h1000 + 32'(4 * (TW - 1)));
        end
`endif
    endtask

    task automatic test_pattern();
        fill_zero();
        mem[0] = 8'h01; mem[1] = 8'h02; mem[2] = 8'h04; mem[3] = 8'h80;
        scan_start(32'h0002_0000, 0);
        scan_finish(0);
        tests_run++;
        if (first_a !== 32'h0002_0000 || first_d !== 32'h8004_0201) begin
            fails++; $display("FAIL pattern_first got=%h/%h want=00020000/80040201", first_a, first_d);
        end
    endtask

    task automatic test_backpressure();
        fill_random();
        mem[12] = 8'h3C;
        stall_word = 3; stall_len = 20;
        scan_start(32'h0040_0000, 2);
        scan_finish(2);
        tests_run++;
        if (stall_left !== 0) begin fails++; $display("FAIL stall_applied got=%0d want=0", stall_left); end
        tests_run++;
        if (stall_reads !== 0) begin fails++; $display("FAIL reads_during_stall got=%0d want=0", stall_reads); end
        stall_word = -1; stall_len = 0;
    endtask

    task automatic test_random_latency();
        fill_random();
        lat_min = 1; lat_max = 6; rand_stall = 1;
        scan_start(32'hFFFF_F000, 1);
        repeat (40) tick();
        fb_base = 32'h7777_0000;
        start   = 1'b1;
        tick();
        start   = 1'b0;
        scan_finish(1);
        tests_run++;
        if (max_out > FIFO_DEPTH) begin fails++; $display("FAIL max_outstanding got=%0d want<=%0d", max_out, FIFO_DEPTH); end
        rand_stall = 0; lat_min = 1; lat_max = 1;
    endtask

    task automatic test_reset_mid_scan();
        int i;
        fill_random();
        lat_min = 4; lat_max = 4;
        scan_start(32'h0000_8000, 0);
        i = 0;
        while (!(wr_cnt >= 100 && b_out == 3) && i < 5000) begin tick(); i++; end
        tests_run++;
        if (i >= 5000) begin fails++; $display("FAIL reset_point_timeout got=%0d want=100", wr_cnt); end
        reset = 1'b1;
        exp_q.delete();
        foreach (pend_q[k]) pend_q[k].live = 1'b0;
        b_out = 0;
        repeat (3) tick();
        check_reset_outputs("midreset");
        reset = 1'b0;
        wr_cnt = 0;
        repeat (15) tick();
        tests_run++;
        if (wr_cnt !== 0 || busy !== 1'b0 || cread !== 1'b0) begin
            fails++; $display("FAIL after_reset got=%0d/%b/%b want=0/0/0", wr_cnt, busy, cread);
        end
        fill_random();
        lat_min = 2; lat_max = 5;
        scan_start(32'h0010_0000, 3);
        scan_finish(3);
        lat_min = 1; lat_max = 1;
    endtask

    task automatic test_last_byte();
        fill_zero();
        mem[TB-1] = 8'hFF;
        scan_start(32'h0000_1000, 0);
        scan_finish(0);
        tests_run++;
        if (last_a !== 32'h1000 + 32'(4 * (TW - 1)) || last_d !== 32'hFF00_0000) begin
            fails++; $display("FAIL last_byte got=%h/%h want=%h/ff000000", last_a, last_d, 32'h1000 + 32'(4 * (TW - 1)));
        end
    endtask

    initial begin
        test_reset();
        test_zero_scan();
        test_pattern();
        test_backpressure();
        test_random_latency();
        test_reset_mid_scan();
        test_last_byte();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end
endmodule
